// File: rtl/pf_iod_rx_align_pkg.sv
// Shared types and defaults for the RX word aligner.
// Optional delay-tap sweep is enabled by defining PF_IOD_RX_ALIGN_DLY_SWEEP_EN.
package pf_iod_rx_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_CHECK    = 3'd2,
    ST_SLIP     = 3'd3,
    ST_DLY_MOVE = 3'd4,
    ST_LOCKED   = 3'd5,
    ST_FAIL     = 3'd6
  } align_state_e;

  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hB4;
  localparam int         DEF_MATCH_COUNT   = 16;
  localparam int         DEF_SETTLE_CYCLES = 8;
  localparam int         DEF_MAX_TAPS      = 128;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pf_iod_rx_align_match_cnt.sv
// Training-word compare and consecutive-match counter.
// match_done_o fires combinationally on the MATCH_COUNT-th consecutive match;
// any mismatch while enabled restarts the run from zero.
module pf_iod_rx_align_match_cnt
  import pf_iod_rx_align_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(DEF_TRAIN_PATTERN),
  parameter int                    MATCH_COUNT   = DEF_MATCH_COUNT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  match_o,
  output logic                  match_done_o
);

  localparam int            CW   = cnt_w(MATCH_COUNT);
  localparam logic [CW-1:0] LAST = CW'(MATCH_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign match_o      = (data_i == TRAIN_PATTERN);
  assign match_done_o = en_i & match_o & (cnt_q == LAST);

  // Count consecutive matches; restart on mismatch, on completion or on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (!match_o || (cnt_q == LAST)) cnt_d = '0;
      else                             cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pf_iod_rx_word_align.sv
// RX word aligner: bit-slips the deserializer (and optionally sweeps the
// clock-divider delay line) until the training word is seen MATCH_COUNT
// times in a row. All outputs are registered from the next-state decode.
// Optional feature macro: PF_IOD_RX_ALIGN_DLY_SWEEP_EN (delay-tap sweep).
module pf_iod_rx_word_align
  import pf_iod_rx_align_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(DEF_TRAIN_PATTERN),
  parameter int                    MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int                    SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int                    MAX_TAPS      = DEF_MAX_TAPS,
  localparam int                   SLIP_W        = cnt_w(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  DELAY_LINE_OUT_OF_RANGE,
  output logic                  BIT_SLIP,
  output logic                  DELAY_LINE_MOVE,
  output logic                  DELAY_LINE_DIR,
  output logic                  DELAY_LINE_LOAD,
  output logic                  BUSY,
  output logic                  LOCKED,
  output logic                  FAIL,
  output logic [SLIP_W-1:0]     SLIP_COUNT,
  output logic [7:0]            TAP_COUNT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID
);

  localparam int                SET_W       = cnt_w(SETTLE_CYCLES);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(DATA_WIDTH - 1);

  align_state_e          state_q, state_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic [SLIP_W-1:0]     slip_cnt_q, slip_d;
  logic                  start_acc;
  logic                  match, match_done;

  logic                  bit_slip_q, busy_q, locked_q, fail_q, valid_q;
  logic [DATA_WIDTH-1:0] data_q;

`ifdef PF_IOD_RX_ALIGN_DLY_SWEEP_EN
  localparam logic [7:0] TAP_LAST = 8'(MAX_TAPS - 1);
  logic [7:0] tap_cnt_q, tap_d;
  logic       move_q, load_q;
`endif

  pf_iod_rx_align_match_cnt #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .MATCH_COUNT   (MATCH_COUNT)
  ) u_match (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .clr_i        (start_acc),
    .en_i         (state_q == ST_CHECK),
    .data_i       (RX_DATA),
    .match_o      (match),
    .match_done_o (match_done)
  );

  // Next-state and counter update logic.
  always_comb begin
    state_d   = state_q;
    settle_d  = '0;
    slip_d    = slip_cnt_q;
    start_acc = 1'b0;
`ifdef PF_IOD_RX_ALIGN_DLY_SWEEP_EN
    tap_d     = tap_cnt_q;
`endif
    case (state_q)
      // START only matters in the resting states; training restarts from scratch.
      ST_IDLE, ST_LOCKED, ST_FAIL: begin
        if (START) begin
          start_acc = 1'b1;
          state_d   = ST_SETTLE;
          slip_d    = '0;
`ifdef PF_IOD_RX_ALIGN_DLY_SWEEP_EN
          tap_d     = '0;
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d  = ST_CHECK;
        else                         settle_d = settle_q + 1'b1;
      end
      ST_CHECK: begin
        if (match_done) begin
          state_d = ST_LOCKED;
        end else if (!match) begin
          if (slip_cnt_q < SLIP_LAST) begin
            state_d = ST_SLIP;
            slip_d  = slip_cnt_q + 1'b1;
          end else begin
`ifdef PF_IOD_RX_ALIGN_DLY_SWEEP_EN
            // Every slip position tried at this tap: step the delay line,
            // unless it has run out of range or hit the sweep limit.
            if (DELAY_LINE_OUT_OF_RANGE || (tap_cnt_q == TAP_LAST)) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_DLY_MOVE;
              tap_d   = tap_cnt_q + 1'b1;
              slip_d  = '0;
            end
`else
            state_d = ST_FAIL;
`endif
          end
        end
      end
      ST_SLIP:     state_d = ST_SETTLE;
      ST_DLY_MOVE: state_d = ST_SETTLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; pulses last exactly one state cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      slip_cnt_q <= '0;
      bit_slip_q <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      slip_cnt_q <= slip_d;
      bit_slip_q <= (state_d == ST_SLIP);
      busy_q     <= (state_d inside {ST_SETTLE, ST_CHECK, ST_SLIP, ST_DLY_MOVE});
      locked_q   <= (state_d == ST_LOCKED);
      fail_q     <= (state_d == ST_FAIL);
      valid_q    <= (state_d == ST_LOCKED);
      data_q     <= (state_d == ST_LOCKED) ? RX_DATA : '0;
    end
  end

`ifdef PF_IOD_RX_ALIGN_DLY_SWEEP_EN
  // Delay-line sweep registers: tap counter, move strobe and load strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tap_cnt_q <= '0;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      tap_cnt_q <= tap_d;
      move_q    <= (state_d == ST_DLY_MOVE);
      load_q    <= start_acc;
    end
  end

  assign DELAY_LINE_MOVE = move_q;
  assign DELAY_LINE_DIR  = move_q;
  assign DELAY_LINE_LOAD = load_q;
  assign TAP_COUNT       = tap_cnt_q;
`else
  // Sweep disabled: delay-line controls idle, range flag has no effect.
  logic [8:0] unused_dly;
  assign unused_dly      = {DELAY_LINE_OUT_OF_RANGE, 8'(MAX_TAPS - 1)};
  assign DELAY_LINE_MOVE = 1'b0;
  assign DELAY_LINE_DIR  = 1'b0;
  assign DELAY_LINE_LOAD = 1'b0;
  assign TAP_COUNT       = '0;
`endif

  assign BIT_SLIP   = bit_slip_q;
  assign BUSY       = busy_q;
  assign LOCKED     = locked_q;
  assign FAIL       = fail_q;
  assign SLIP_COUNT = slip_cnt_q;
  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;

endmodule

// File: doc/pf_iod_rx_word_align.md
PF_IOD_RX_WORD_ALIGN -- requirements
Module: pf_iod_rx_word_align

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the deserialized word per divided-clock cycle.
REQ-002 SHALL have parameter TRAIN_PATTERN, default 8'hB4: the expected aligned training word.
REQ-003 SHALL have parameter MATCH_COUNT, default 16: the number of consecutive matches required to lock.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8: the number of wait cycles after start, slip or delay move.
REQ-005 SHALL have parameter MAX_TAPS, default 128: the delay-tap sweep limit (used only when the macro is defined).
REQ-006 SHALL have ports CLK in 1 (divided RX clock, sole clock) and RESET in 1, where reset is synchronous and active-high.
REQ-007 SHALL have ports START in 1 (one-cycle training request) and RX_DATA in DATA_WIDTH (raw word from the deserializer).
REQ-008 SHALL have port DELAY_LINE_OUT_OF_RANGE in 1, driven from the clock-divider delay line.
REQ-009 SHALL have ports BIT_SLIP out 1, DELAY_LINE_MOVE out 1, DELAY_LINE_DIR out 1 and DELAY_LINE_LOAD out 1, all driving the clock-divider/delay block.
REQ-010 SHALL have ports BUSY out 1, LOCKED out 1 and FAIL out 1.
REQ-011 SHALL have ports SLIP_COUNT out clog2(DATA_WIDTH) and TAP_COUNT out 8.
REQ-012 SHALL have ports DATA_OUT out DATA_WIDTH and DATA_VALID out 1.

Function
REQ-013 SHALL implement the states IDLE, SETTLE, CHECK, SLIP, DLY_MOVE, LOCKED and FAIL, with all outputs registered.
REQ-014 IDLE: on START=1, SHALL go to SETTLE, clear SLIP_COUNT, TAP_COUNT and the match counter, and pulse DELAY_LINE_LOAD for one cycle (macro builds only).
REQ-015 SETTLE: SHALL wait exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-016 CHECK, match (RX_DATA==TRAIN_PATTERN): SHALL increment the match counter; on the MATCH_COUNT-th consecutive match it SHALL go to LOCKED on the next cycle.
REQ-017 CHECK, mismatch: SHALL clear the match counter; if SLIP_COUNT<DATA_WIDTH-1 it SHALL go to SLIP, else it SHALL treat the slip positions as exhausted.
REQ-018 SLIP: SHALL assert BIT_SLIP for exactly one cycle, increment SLIP_COUNT, then go to SETTLE.
REQ-019 Exhausted slips: SHALL go to DLY_MOVE (macro builds) or FAIL (non-macro builds).
REQ-020 DLY_MOVE: SHALL assert DELAY_LINE_MOVE=1 and DELAY_LINE_DIR=1 for one cycle, increment TAP_COUNT, clear SLIP_COUNT, then go to SETTLE.
REQ-021 DLY_MOVE entry: if DELAY_LINE_OUT_OF_RANGE=1 or TAP_COUNT==MAX_TAPS-1, SHALL go to FAIL instead and SHALL NOT pulse DELAY_LINE_MOVE.
REQ-022 LOCKED: SHALL hold LOCKED=1 and DATA_VALID=1; DATA_OUT SHALL equal RX_DATA delayed by one cycle.
REQ-023 LOCKED/FAIL: START=1 SHALL restart exactly as from IDLE.
REQ-024 START SHALL be ignored in SETTLE, CHECK, SLIP and DLY_MOVE.
REQ-025 BUSY SHALL be 1 in SETTLE, CHECK, SLIP and DLY_MOVE, and 0 otherwise.
REQ-026 FAIL: SHALL hold FAIL=1, with DATA_VALID=0 and DATA_OUT=0.
REQ-027 SHALL never assert BIT_SLIP, DELAY_LINE_MOVE and DELAY_LINE_LOAD in the same cycle.
REQ-028 SHALL not allow counters to wrap: SLIP_COUNT SHALL be capped at DATA_WIDTH-1 and TAP_COUNT at MAX_TAPS-1.

Reset
REQ-029 RESET=1 SHALL force IDLE and drive all outputs and counters to 0 on the next CLK edge, including mid-slip or mid-move (any pulse SHALL end that cycle).
REQ-030 Reset SHALL take priority over START asserted in the same cycle.

Configuration
REQ-031 Macro PF_IOD_RX_ALIGN_DLY_SWEEP_EN, when defined, SHALL enable the DLY_MOVE state, the DELAY_LINE_LOAD pulse and the TAP_COUNT sweep.
REQ-032 When PF_IOD_RX_ALIGN_DLY_SWEEP_EN is undefined: DELAY_LINE_MOVE, DELAY_LINE_DIR, DELAY_LINE_LOAD and TAP_COUNT SHALL be tied to 0, DELAY_LINE_OUT_OF_RANGE SHALL be ignored, and slip exhaustion SHALL lead to FAIL.

Structure
REQ-033 Package pf_iod_rx_align_pkg SHALL hold the state enum, default TRAIN_PATTERN and default MATCH_COUNT/SETTLE_CYCLES constants.
REQ-034 One sub-module, pf_iod_rx_align_match_cnt, SHALL hold the pattern compare and consecutive-match counter; it SHALL output match_done.

Verification
REQ-035 Aligned stream: RX_DATA=8'hB4 constantly, START pulse -> LOCKED=1 at 1+8+16(+1) cycles, SLIP_COUNT=0, no BIT_SLIP.
REQ-036 Stream rotated by 3 bits, with the model rotating by 1 per BIT_SLIP -> exactly 3 BIT_SLIP pulses, each separated by 8 settle cycles, then LOCKED with SLIP_COUNT=3.
REQ-037 Pattern never present, non-macro build -> 7 BIT_SLIP pulses, then FAIL=1, BUSY=0.
REQ-038 Macro build, pattern valid only after 5 taps -> DELAY_LINE_LOAD once, 5 DELAY_LINE_MOVE pulses with DIR=1, LOCKED with TAP_COUNT=5; asserting DELAY_LINE_OUT_OF_RANGE at tap 2 instead -> FAIL with TAP_COUNT=2.
REQ-039 Inject a single mismatch at match 10 -> match counter restarts and one BIT_SLIP is issued; RESET asserted during a BIT_SLIP cycle -> all outputs 0 next cycle and state IDLE.
REQ-040 In LOCKED, a START pulse -> BUSY=1 and LOCKED=0 next cycle, and training repeats.
